// File: rtl/j_clkdiv.sv
// j_clkdiv: programmable 6-bit clock-enable divider with shadowed period/threshold
// Ports:
//   sys_clk, reset      clock and synchronous active-high reset
//   din, per_wr, thr_wr shadow register write data and strobes
//   load                restart count and promote shadows immediately
//   en                  count enable
//   cnt, tick, ckout    running count, period-start pulse, divided clock level
//   pending             a shadow write awaits promotion
module j_clkdiv (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [5:0] din,
    input  logic       per_wr,
    input  logic       thr_wr,
    input  logic       load,
    input  logic       en,
    output logic [5:0] cnt,
    output logic       tick,
    output logic       ckout,
    output logic       pending
);
    logic [5:0] per_act, thr_act, per_sh, thr_sh;
    logic [5:0] cnt_n, per_act_n, thr_act_n, per_sh_n, thr_sh_n;
    logic       pending_n, tick_n, wrap, wr;
    always_comb begin
        wr        = per_wr | thr_wr;
        wrap      = en && (cnt == per_act);
        per_sh_n  = per_wr ? din : per_sh;
        thr_sh_n  = thr_wr ? din : thr_sh;
        // load promotes the written-through shadows; a wrap promotes the old ones
        cnt_n     = (load || wrap) ? 6'd0 : en ? cnt + 6'd1 : cnt;
        per_act_n = load ? per_sh_n : wrap ? per_sh : per_act;
        thr_act_n = load ? thr_sh_n : wrap ? thr_sh : thr_act;
        pending_n = load ? 1'b0 : wrap ? wr : pending | wr;
        tick_n    = load || wrap;
    end
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt     <= 6'd0;
            per_act <= 6'd63;
            thr_act <= 6'd31;
            per_sh  <= 6'd63;
            thr_sh  <= 6'd31;
            pending <= 1'b0;
            tick    <= 1'b0;
            ckout   <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            per_act <= per_act_n;
            thr_act <= thr_act_n;
            per_sh  <= per_sh_n;
            thr_sh  <= thr_sh_n;
            pending <= pending_n;
            tick    <= tick_n;
            ckout   <= cnt_n > thr_act_n;
        end
    end
endmodule

// File: tb/tb_j_clkdiv.sv
// tb_j_clkdiv: scoreboard bench for j_clkdiv
module tb_j_clkdiv;
    logic       sys_clk = 1'b0;
    logic       reset = 1'b1, per_wr = 1'b0, thr_wr = 1'b0, load = 1'b0, en = 1'b0;
    logic [5:0] din = 6'd0;
    logic [5:0] cnt;
    logic       tick, ckout, pending;
    typedef struct packed {
        logic [5:0] cnt;
        logic       tick;
        logic       ckout;
        logic       pending;
    } exp_t;
    exp_t q[$];
    int errors = 0, checks = 0, hi;
    logic [5:0] m_cnt = 0, m_pa = 63, m_ta = 31, m_ps = 63, m_ts = 31;
    logic       m_tick = 0, m_pend = 0;
    j_clkdiv dut (
        .sys_clk(sys_clk), .reset(reset), .din(din), .per_wr(per_wr), .thr_wr(thr_wr),
        .load(load), .en(en), .cnt(cnt), .tick(tick), .ckout(ckout), .pending(pending)
    );
    always #5 sys_clk = ~sys_clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input logic r, input logic ld, input logic e, input logic pw,
                        input logic tw, input logic [5:0] d);
        exp_t x;
        logic [5:0] ops, ots;
        reset = r; load = ld; en = e; per_wr = pw; thr_wr = tw; din = d;
        ops = m_ps; ots = m_ts;
        if (r) begin
            m_cnt = 0; m_pa = 63; m_ta = 31; m_ps = 63; m_ts = 31; m_tick = 0; m_pend = 0;
        end else begin
            if (pw) m_ps = d;
            if (tw) m_ts = d;
            if (ld) begin
                m_cnt = 0; m_pa = m_ps; m_ta = m_ts; m_pend = 0; m_tick = 1;
            end else if (e && m_cnt == m_pa) begin
                m_cnt = 0; m_pa = ops; m_ta = ots; m_pend = pw | tw; m_tick = 1;
            end else begin
                if (e) m_cnt = m_cnt + 1;
                m_pend = m_pend | pw | tw;
                m_tick = 0;
            end
        end
        q.push_back('{m_cnt, m_tick, m_cnt > m_ta, m_pend});
        @(posedge sys_clk);
        #1;
        if (q.size() == 0) check("queue_empty", 0, 1);
        else begin
            x = q.pop_front();
            check("cnt", cnt, x.cnt);
            check("tick", tick, x.tick);
            check("ckout", ckout, x.ckout);
            check("pending", pending, x.pending);
        end
        per_wr = 0; thr_wr = 0; load = 0;
    endtask
    task automatic run_to(input logic [5:0] c);
        for (int i = 0; i < 200 && m_cnt != c; i++) step(0, 0, 1, 0, 0, 0);
    endtask
    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        check("t1_reset_cnt", cnt, 0);
        hi = 0;
        for (int i = 0; i < 64; i++) begin
            step(0, 0, 1, 0, 0, 0);
            hi += ckout;
        end
        check("t1_duty", hi, 32);
        check("t1_tick64", tick, 1);
        run_to(20);
        step(0, 0, 1, 0, 1, 5);
        step(0, 0, 1, 1, 0, 9);
        check("t2_pending", pending, 1);
        run_to(63);
        step(0, 0, 1, 0, 0, 0);
        check("t2_promoted", pending, 0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0, 0);
            hi += ckout;
        end
        check("t2_duty", hi, 4);
        check("t2_tick10", tick, 1);
        step(0, 1, 1, 1, 0, 63);
        run_to(63);
        step(0, 0, 1, 1, 0, 3);
        check("t3_cnt", cnt, 0);
        check("t3_pending", pending, 1);
        for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 0, 0);
        check("t3_wrap2", tick, 1);
        check("t3_pend_clr", pending, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
        check("t3_period4", tick, 1);
        step(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0, 0);
            check("t4_tick", tick, 1);
            check("t4_ckout", ckout, 0);
        end
        step(0, 1, 1, 1, 0, 63);
        run_to(62);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("t5_hold", cnt, 62);
        check("t5_tick0", tick, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("t5_wrap", tick, 1);
        step(0, 0, 1, 0, 1, 5);
        step(0, 1, 1, 1, 0, 9);
        run_to(7);
        step(1, 0, 1, 0, 0, 0);
        check("t6_cnt", cnt, 0);
        check("t6_pending", pending, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, 6'($urandom_range(0, 15)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
